// File: rtl/instruction_loader.sv
// Byte-stream loader into a 256-byte instruction memory; big-endian word read port for fetch.
// Latency: accepted byte visible on fetch_word the cycle after its handshake; fetch path is combinational.
// Backpressure: s_ready only while loading and no start_load pulse; RUN/ERR/IDLE refuse all bytes.
module instruction_loader #(
    parameter int MEM_BYTES = 256,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_load,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic              s_ready,
    input  logic [31:0]       fetch_addr,
    output logic [31:0]       fetch_word,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              overflow_err,
    output logic [ADDR_W:0]   load_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(MEM_BYTES - 1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

    state_t            state;
    state_t            state_next;
    logic [7:0]        mem [MEM_BYTES];
    logic [ADDR_W-1:0] ptr;
    logic              accept;

    assign s_ready = (state == LOAD) && !start_load;
    assign accept  = s_valid && s_ready;

    // s_last wins over overflow so a program of exactly MEM_BYTES bytes is legal.
    always_comb begin
        state_next = state;
        if (start_load) begin
            state_next = LOAD;
        end else if (accept) begin
            if (s_last) begin
                state_next = RUN;
            end else if (ptr == PTR_LAST) begin
                state_next = ERR;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cpu_reset    <= 1'b1;
            load_done    <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            state        <= state_next;
            cpu_reset    <= (state_next != RUN);
            load_done    <= (state_next == RUN);
            overflow_err <= (state_next == ERR);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr        <= '0;
            load_count <= '0;
        end else if (start_load) begin
            ptr        <= '0;
            load_count <= '0;
        end else if (accept) begin
            ptr        <= ptr + PTR_ONE;
            load_count <= load_count + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (start_load) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (accept) begin
            mem[ptr] <= s_data;
        end
    end

    // Byte indices wrap naturally in ADDR_W bits; upper PC bits are don't-care.
    logic [ADDR_W-1:0] rd_a0;
    logic [ADDR_W-1:0] rd_a1;
    logic [ADDR_W-1:0] rd_a2;
    logic [ADDR_W-1:0] rd_a3;
    logic              unused_fetch_hi;

    assign rd_a0           = fetch_addr[ADDR_W-1:0];
    assign rd_a1           = rd_a0 + PTR_ONE;
    assign rd_a2           = rd_a1 + PTR_ONE;
    assign rd_a3           = rd_a2 + PTR_ONE;
    assign fetch_word      = {mem[rd_a0], mem[rd_a1], mem[rd_a2], mem[rd_a3]};
    assign unused_fetch_hi = ^fetch_addr[31:ADDR_W];

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: behavioural model checked every cycle plus literal spot checks.
module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_load = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [31:0] fetch_addr = 32'h0;
    logic [31:0] fetch_word;
    logic        cpu_reset;
    logic        load_done;
    logic        overflow_err;
    logic [8:0]  load_count;

    int checks = 0;
    int errors = 0;

    instruction_loader #(.MEM_BYTES(256), .ADDR_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_load   (start_load),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .fetch_addr   (fetch_addr),
        .fetch_word   (fetch_word),
        .cpu_reset    (cpu_reset),
        .load_done    (load_done),
        .overflow_err (overflow_err),
        .load_count   (load_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a byte array filled in arrival order, plus three phase flags.
    logic [7:0] m_mem [256];
    int         m_count = 0;
    bit         m_loading = 1'b0;
    bit         m_running = 1'b0;
    bit         m_errored = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset || start_load) begin
            foreach (m_mem[i]) m_mem[i] = 8'h00;
            m_count   = 0;
            m_loading = !reset;
            m_running = 1'b0;
            m_errored = 1'b0;
        end else if (m_loading && s_valid) begin
            m_mem[m_count] = s_data;
            m_count++;
            if (s_last) begin
                m_loading = 1'b0;
                m_running = 1'b1;
            end else if (m_count == 256) begin
                m_loading = 1'b0;
                m_errored = 1'b1;
            end
        end
    end

    function automatic logic [31:0] m_word(input logic [31:0] addr);
        logic [7:0] a;
        a = addr[7:0];
        return {m_mem[a], m_mem[8'(a + 8'd1)], m_mem[8'(a + 8'd2)], m_mem[8'(a + 8'd3)]};
    endfunction

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_s_ready", 32'(s_ready), 32'(m_loading && !start_load));
            check("cyc_cpu_reset", 32'(cpu_reset), 32'(!m_running));
            check("cyc_load_done", 32'(load_done), 32'(m_running));
            check("cyc_overflow_err", 32'(overflow_err), 32'(m_errored));
            check("cyc_load_count", 32'(load_count), 32'(m_count));
            check("cyc_fetch_word", fetch_word, m_word(fetch_addr));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        cyc();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic pulse_start();
        start_load = 1'b1;
        cyc();
        start_load = 1'b0;
    endtask

    task automatic chk_word(input string name, input logic [31:0] addr, input logic [31:0] exp);
        fetch_addr = addr;
        #1;
        check(name, fetch_word, exp);
    endtask

    logic [7:0] prog [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};

    initial begin
        repeat (2) cyc();
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_overflow_err", 32'(overflow_err), 32'd0);
        check("rst_load_count", 32'(load_count), 32'd0);
        chk_word("rst_fetch0", 32'h0, 32'h0000_0000);
        cmp_en = 1'b1;
        reset  = 1'b0;
        cyc();

        // Basic contiguous load
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            send(prog[i], i == 7);
            if (i == 6) check("basic_cpu_reset_before_last", 32'(cpu_reset), 32'd1);
        end
        check("basic_cpu_reset_on_last", 32'(cpu_reset), 32'd0);
        check("basic_load_done", 32'(load_done), 32'd1);
        check("basic_load_count", 32'(load_count), 32'd8);
        chk_word("basic_w0", 32'h0, 32'h2008_0005);
        chk_word("basic_w4", 32'h4, 32'h8C09_0004);
        chk_word("basic_w8", 32'h8, 32'h0000_0000);
        cyc();
        chk_word("basic_unaligned1", 32'h1, 32'h0800_058C);
        chk_word("basic_upper_ignored", 32'hABCD_0104, 32'h8C09_0004);
        cyc();

        // Reload from RUN with a concurrent byte offered
        start_load = 1'b1;
        s_valid    = 1'b1;
        s_data     = 8'hAA;
        s_last     = 1'b1;
        cyc();
        start_load = 1'b0;
        s_valid    = 1'b0;
        s_last     = 1'b0;
        check("reload_count_zero", 32'(load_count), 32'd0);
        check("reload_cpu_reset", 32'(cpu_reset), 32'd1);
        chk_word("reload_w0_cleared", 32'h0, 32'h0000_0000);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h0C, 1'b1);
        chk_word("reload_w0", 32'h0, 32'h0000_000C);
        check("reload_count", 32'(load_count), 32'd4);
        cyc();

        // Gapped stream with junk on idle cycles
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b0;
            s_data  = 8'hFF;
            s_last  = 1'b1;
            cyc();
            send(prog[i], i == 7);
        end
        s_data = 8'hFF;
        chk_word("gap_w0", 32'h0, 32'h2008_0005);
        chk_word("gap_w4", 32'h4, 32'h8C09_0004);
        chk_word("gap_w8", 32'h8, 32'h0000_0000);
        check("gap_load_count", 32'(load_count), 32'd8);
        cyc();

        // Overflow: 256 bytes, never s_last
        pulse_start();
        for (int i = 0; i < 256; i++) send(8'(i), 1'b0);
        check("ovf_err", 32'(overflow_err), 32'd1);
        check("ovf_count", 32'(load_count), 32'd256);
        check("ovf_cpu_reset", 32'(cpu_reset), 32'd1);
        check("ovf_s_ready", 32'(s_ready), 32'd0);
        chk_word("ovf_wrap_fe", 32'hFE, 32'hFEFF_0001);
        send(8'h55, 1'b0);
        check("ovf_count_held", 32'(load_count), 32'd256);
        cyc();

        // Exactly 256 bytes with s_last on the final one
        pulse_start();
        for (int i = 0; i < 256; i++) send(8'(255 - i), i == 255);
        check("full_load_done", 32'(load_done), 32'd1);
        check("full_no_err", 32'(overflow_err), 32'd0);
        check("full_count", 32'(load_count), 32'd256);
        chk_word("full_wrap_fd", 32'hFD, 32'h0201_00FF);
        cyc();

        // Asynchronous reset mid-load
        pulse_start();
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        reset = 1'b1;
        #1;
        check("arst_count", 32'(load_count), 32'd0);
        check("arst_s_ready", 32'(s_ready), 32'd0);
        chk_word("arst_w0", 32'h0, 32'h0000_0000);
        cyc();
        reset = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h44;
        repeat (3) cyc();
        check("arst_idle_s_ready", 32'(s_ready), 32'd0);
        check("arst_idle_count", 32'(load_count), 32'd0);
        s_valid = 1'b0;
        repeat (2) cyc();

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Writer side of the instruction memory that instruction fetch reads.
- Accepts a program as a byte stream over a valid/ready handshake and stores it in a 256-byte instruction memory.
- Serves big-endian 32-bit words to fetch combinationally.
- Holds the processor in reset until a load completes cleanly.

Parameters:
MEM_BYTES, 256, instruction memory size in bytes; must be a power of two.
ADDR_W, 8, byte address width, equal to log2(MEM_BYTES).

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
start_load  input  1  single-cycle pulse; clears memory and begins a new load.
s_valid  input  1  byte stream valid.
s_data  input  8  byte stream data; first byte goes to address 0.
s_last  input  1  marks the final program byte; sampled only on handshake.
s_ready  output  1  loader can accept a byte this cycle.
fetch_addr  input  32  byte address from instruction fetch (PC).
fetch_word  output  32  instruction word at fetch_addr.
cpu_reset  output  1  registered reset to the processor datapath; 1 unless state is RUN.
load_done  output  1  registered; 1 while in RUN.
overflow_err  output  1  registered; 1 while in ERR.
load_count  output  ADDR_W+1  bytes accepted in the current or last load, range 0..MEM_BYTES.

Behaviour:
- States: IDLE, LOAD, RUN, ERR.
- On reset (asynchronous):
  - state=IDLE, all memory bytes=0, write pointer=0, load_count=0.
  - cpu_reset=1, load_done=0, overflow_err=0.
  - s_ready=0; fetch_word=0 at any address.
- Handshake:
  - A byte is accepted on a rising edge where s_valid && s_ready.
  - s_ready = (state==LOAD) && !start_load, combinational.
  - s_valid may drop at any time; gaps are allowed with no timeout.
  - s_data and s_last are ignored when there is no handshake.
- Accepted byte:
  - mem[ptr] <= s_data, ptr <= ptr+1, load_count <= load_count+1.
  - One byte per cycle maximum; zero extra latency.
- start_load, in any state except during reset:
  - Next edge: all bytes cleared to 0, ptr=0, load_count=0, overflow_err=0, state=LOAD, cpu_reset=1.
  - Takes priority over a concurrent byte (s_ready is 0 that cycle).
  - Restarting mid-LOAD discards the partial program.
- Transitions out of LOAD:
  - Accepted byte with s_last=1 → RUN. That byte is written, and load_done=1 and cpu_reset=0 from the same edge.
  - Accepted byte with s_last=0 when ptr==MEM_BYTES-1 (256th byte) → ERR. The byte is written, load_count=256, overflow_err=1, cpu_reset stays 1.
  - 256th byte with s_last=1 → RUN, not ERR.
- RUN and ERR persist until start_load or reset. s_ready=0 in both states.
- Empty program: not possible; s_last is the only way to RUN, and at least 1 byte is required.
- Unloaded bytes read as 0, so 0x00000000 executes as a nop.
- Fetch read port, valid in all states:
  - Combinational: a = fetch_addr[ADDR_W-1:0].
  - fetch_word = {mem[a], mem[a+1], mem[a+2], mem[a+3]}, with indices mod MEM_BYTES (wrap-around).
  - Unaligned addresses are permitted and follow the same rule.
  - Upper fetch_addr bits are ignored.
- Same-cycle write and read of the same byte: fetch_word shows the old value until the edge.
- Reset mid-LOAD: immediate return to IDLE with memory cleared; the stream is not acknowledged afterward.

Test Plan:
- Reset checks: assert reset → s_ready=0, cpu_reset=1, load_done=0, overflow_err=0, load_count=0, fetch_word=0x00000000 at fetch_addr=0.
- Basic load: start_load, then bytes 20 08 00 05 8C 09 00 04 contiguously with s_last on byte 8 → fetch_word(0)=0x20080005, fetch_word(4)=0x8C090004, fetch_word(8)=0, load_count=8, load_done=1, and cpu_reset=0 on the edge accepting byte 8.
- Gapped stream: same 8 bytes with s_valid low on alternate cycles, plus s_data=0xFF while s_valid=0 → identical memory contents; no 0xFF written.
- Overflow: 256 bytes 0x00..0xFF with s_last never set → overflow_err=1, load_count=256, cpu_reset=1, s_ready=0; fetch_word(0xFE)=0xFEFF0001, showing wrap.
- Reload from RUN: after the basic load, pulse start_load while s_valid=1 → no byte accepted that cycle, cpu_reset=1 next edge, fetch_word(0)=0. Then load bytes 00 00 00 0C with s_last → fetch_word(0)=0x0000000C.
- Reset mid-load: after 3 accepted bytes, assert reset for 1 cycle → state IDLE, fetch_word(0)=0, load_count=0; s_ready stays 0 until the next start_load.
